// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel fetch stage.
//   - Visible-area and colour-bar constants
//   - rgb_t: one 24-bit DAC colour
//   - src_mode_e: pixel source select
//   - BAR_COLOURS: the eight colour-bar colours, left to right
//   - rgb332_expand / bar_index: helpers shared by the datapath
package vga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int V_VISIBLE = 600;
  localparam int BAR_WIDTH = 100;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FB      = 2'd0,
    BARS    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } src_mode_e;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Bit replication keeps full-scale codes at full scale (7 -> FF, 3 -> FF).
  function automatic rgb_t rgb332_expand(input logic [7:0] d);
    rgb_t c;
    c.r = {d[7:5], d[7:5], d[7:6]};
    c.g = {d[4:2], d[4:2], d[4:3]};
    c.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    return c;
  endfunction

  // x / BAR_WIDTH as a compare chain; coordinates past the last bar clamp to 7.
  function automatic logic [2:0] bar_index(input logic [11:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 12'(i * BAR_WIDTH)) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to carry timing, source mode and pattern
// colour alongside the framebuffer read.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low clear, every stage loads RST_VAL
//   d_i     : WIDTH-bit input word
//   q_o     : input word delayed by DEPTH cycles
module vga_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage between the VGA timing controller and the DAC.
// Reads a downscaled RGB332 framebuffer or generates a test pattern, and
// delays the timing signals so colour and sync reach the DAC together.
//   Clock, Reset_n            : pixel clock, async active-low reset
//   nextX, nextY              : coordinate from the timing controller
//   blank_in_n, sync_in_n,
//   hSync_in_n, vSync_in_n    : timing controller outputs
//   mode                      : 0 framebuffer, 1 bars, 2 checker, 3 solid
//   fb_addr, fb_rd_en         : registered framebuffer read request
//   fb_data                   : RGB332 pixel, RAM_LATENCY cycles after request
//   red, green, blue          : DAC colour
//   blank_n, sync_n,
//   hSync_n, vSync_n          : timing delayed by RAM_LATENCY + 2 cycles
//   frame_count               : frames seen (vSync_in_n falling edges)
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int          SCALE_SHIFT = 2,
  parameter int          RAM_LATENCY = 2,
  parameter int          ADDR_W      = 15,
  parameter logic [23:0] SOLID_RGB   = 24'h0000FF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [11:0]       nextX,
  input  logic [11:0]       nextY,
  input  logic              blank_in_n,
  input  logic              sync_in_n,
  input  logic              hSync_in_n,
  input  logic              vSync_in_n,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [7:0]        fb_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              blank_n,
  output logic              sync_n,
  output logic              hSync_n,
  output logic              vSync_n,
  output logic [7:0]        frame_count
);

  localparam int FB_W = H_VISIBLE >> SCALE_SHIFT;
  localparam int DL_W = 4 + 2 + 24;
  // Timing word order is {blank, sync, hsync, vsync}: blanked, syncs inactive.
  localparam logic [3:0]      TIM_RST = 4'b0111;
  localparam logic [DL_W-1:0] DL_RST  = {TIM_RST, 2'b00, 24'h000000};

  // Frame boundary and active mode
  logic       vs_prev_q;
  logic       boundary;
  src_mode_e  mode_q, mode_d;
  logic [7:0] frame_count_q, frame_count_d;

  assign boundary = vs_prev_q & ~vSync_in_n;

  // The pixel arriving with the boundary already uses the newly latched mode.
  always_comb begin
    mode_d        = mode_q;
    frame_count_d = frame_count_q;
    if (boundary) begin
      mode_d        = src_mode_e'(mode);
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // S1: coordinate, timing, mode and framebuffer request
  logic [11:0]       x_q;
  logic              y5_q;
  logic [3:0]        tim_s1_q;
  src_mode_e         mode_s1_q;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_rd_en_q, fb_rd_en_d;

  // FB_W is a constant, so the product reduces to shifts and adds.
  assign fb_addr_d  = ADDR_W'(nextY >> SCALE_SHIFT) * ADDR_W'(FB_W)
                    + ADDR_W'(nextX >> SCALE_SHIFT);
  assign fb_rd_en_d = blank_in_n && (mode_d == FB);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev_q     <= 1'b1;
      mode_q        <= FB;
      frame_count_q <= '0;
      x_q           <= '0;
      y5_q          <= 1'b0;
      tim_s1_q      <= TIM_RST;
      mode_s1_q     <= FB;
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
    end else begin
      vs_prev_q     <= vSync_in_n;
      mode_q        <= mode_d;
      frame_count_q <= frame_count_d;
      x_q           <= nextX;
      y5_q          <= nextY[5];
      tim_s1_q      <= {blank_in_n, sync_in_n, hSync_in_n, vSync_in_n};
      mode_s1_q     <= mode_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
    end
  end

  rgb_t pat_rgb;

  always_comb begin
    pat_rgb = '0;
    case (mode_s1_q)
      BARS:    pat_rgb = BAR_COLOURS[bar_index(x_q)];
      CHECKER: if (x_q[5] ^ y5_q ^ frame_count_q[6]) pat_rgb = 24'hFFFFFF;
      SOLID:   pat_rgb = SOLID_RGB;
      default: pat_rgb = '0;
    endcase
  end

  // D1..D_RAM_LATENCY: match the framebuffer read latency
  logic [DL_W-1:0] dl_q;
  logic [3:0]      dl_tim;
  src_mode_e       dl_mode;
  rgb_t            dl_rgb;

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (RAM_LATENCY),
    .RST_VAL (DL_RST)
  ) u_delay (
    .clk_i  (Clock),
    .rst_ni (Reset_n),
    .d_i    ({tim_s1_q, mode_s1_q, pat_rgb}),
    .q_o    (dl_q)
  );

  assign dl_tim  = dl_q[29:26];
  assign dl_mode = src_mode_e'(dl_q[25:24]);
  assign dl_rgb  = rgb_t'(dl_q[23:0]);

  // S_out: source select and blanking
  rgb_t       out_q, out_d;
  logic [3:0] tim_out_q;

  always_comb begin
    out_d = (dl_mode == FB) ? rgb332_expand(fb_data) : dl_rgb;
    if (!dl_tim[3]) out_d = '0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q     <= '0;
      tim_out_q <= TIM_RST;
    end else begin
      out_q     <= out_d;
      tim_out_q <= dl_tim;
    end
  end

  assign red         = out_q.r;
  assign green       = out_q.g;
  assign blue        = out_q.b;
  assign blank_n     = tim_out_q[3];
  assign sync_n      = tim_out_q[2];
  assign hSync_n     = tim_out_q[1];
  assign vSync_n     = tim_out_q[0];
  assign fb_addr     = fb_addr_q;
  assign fb_rd_en    = fb_rd_en_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: a compact timing-controller model
// drives randomized frames, a RAM model answers reads, and a per-pixel
// reference model predicts every DAC output.
module tb_vga_pixel_fetch;

  localparam int RL  = 2;
  localparam int L   = RL + 2;
  localparam int SS  = 2;
  localparam int AW  = 15;
  localparam logic [23:0] SOLID = 24'h0000FF;

  logic          Clock, Reset_n;
  logic [11:0]   nextX, nextY;
  logic          blank_in_n, sync_in_n, hSync_in_n, vSync_in_n;
  logic [1:0]    mode;
  logic [AW-1:0] fb_addr;
  logic          fb_rd_en;
  logic [7:0]    fb_data;
  logic [7:0]    red, green, blue;
  logic          blank_n, sync_n, hSync_n, vSync_n;
  logic [7:0]    frame_count;

  vga_pixel_fetch #(
    .SCALE_SHIFT (SS),
    .RAM_LATENCY (RL),
    .ADDR_W      (AW),
    .SOLID_RGB   (SOLID)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .nextX       (nextX),
    .nextY       (nextY),
    .blank_in_n  (blank_in_n),
    .sync_in_n   (sync_in_n),
    .hSync_in_n  (hSync_in_n),
    .vSync_in_n  (vSync_in_n),
    .mode        (mode),
    .fb_addr     (fb_addr),
    .fb_rd_en    (fb_rd_en),
    .fb_data     (fb_data),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .hSync_n     (hSync_n),
    .vSync_n     (vSync_n),
    .frame_count (frame_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: content is the low address byte, read latency RL cycles.
  logic [AW-1:0] ram_pipe [RL];
  always @(posedge Clock) begin
    ram_pipe[0] <= fb_addr;
    for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign fb_data = ram_pipe[RL-1][7:0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [23:0] rgb;
    logic [3:0]  tim;
  } exp_t;

  exp_t          expq[$];
  int            m_fc, m_mode;
  bit            m_vsprev;
  logic [AW-1:0] exp_addr;
  logic          exp_rd;
  logic [7:0]    exp_fc;
  logic [1:0]    mode_in;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] exp332(input int d);
    int r3, g3, b2, r, g, b;
    r3 = (d >> 5) & 7;
    g3 = (d >> 2) & 7;
    b2 = d & 3;
    r  = (r3 << 5) | (r3 << 2) | (r3 >> 1);
    g  = (g3 << 5) | (g3 << 2) | (g3 >> 1);
    b  = b2 * 85;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic model_reset();
    m_fc     = 0;
    m_mode   = 0;
    m_vsprev = 1'b1;
    exp_addr = '0;
    exp_rd   = 1'b0;
    exp_fc   = 8'd0;
    expq.delete();
    for (int i = 0; i < L - 1; i++) expq.push_back('{rgb: 24'h0, tim: 4'b0111});
  endtask

  task automatic model_push(input int x, input int y, input bit bl, input bit sy,
                            input bit hs, input bit vs, input int md);
    exp_t e;
    int   a;
    if (m_vsprev && !vs) begin
      m_fc   = (m_fc + 1) % 256;
      m_mode = md;
    end
    m_vsprev = vs;
    a        = ((y / (1 << SS)) * (800 / (1 << SS)) + x / (1 << SS)) % (1 << AW);
    exp_addr = AW'(a);
    exp_rd   = bl && (m_mode == 0);
    exp_fc   = 8'(m_fc);
    if (!bl) e.rgb = 24'h0;
    else begin
      case (m_mode)
        0:       e.rgb = exp332(a % 256);
        1:       e.rgb = bars[(x / 100) % 8];
        2:       e.rgb = ((((x / 32) % 2) ^ ((y / 32) % 2) ^ ((m_fc / 64) % 2)) != 0)
                         ? 24'hFFFFFF : 24'h0;
        default: e.rgb = SOLID;
      endcase
    end
    e.tim = {bl, sy, hs, vs};
    expq.push_back(e);
  endtask

  task automatic drive(input int x, input int y, input bit bl, input bit hs, input bit vs);
    nextX      = 12'(x);
    nextY      = 12'(y);
    blank_in_n = bl;
    hSync_in_n = hs;
    vSync_in_n = vs;
    sync_in_n  = hs & vs;
    mode       = mode_in;
    model_push(x, y, bl, hs & vs, hs, vs, int'(mode_in));
  endtask

  // One pixel clock: check what the DUT shows now, then present the next input.
  task automatic tick_pix(input int x, input int y, input bit bl, input bit hs, input bit vs);
    exp_t e;
    @(negedge Clock);
    if (expq.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      check("rgb", {red, green, blue}, e.rgb);
      check("timing", {blank_n, sync_n, hSync_n, vSync_n}, e.tim);
    end
    check("fb_addr", fb_addr, exp_addr);
    check("fb_rd_en", fb_rd_en, exp_rd);
    check("frame_count", frame_count, exp_fc);
    drive(x, y, bl, hs, vs);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"}, {red, green, blue}, 24'h0);
    check({tag, "_timing"}, {blank_n, sync_n, hSync_n, vSync_n}, 4'b0111);
    check({tag, "_addr"}, fb_addr, '0);
    check({tag, "_rd_en"}, fb_rd_en, 1'b0);
    check({tag, "_fc"}, frame_count, 8'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset(input int hold);
    @(posedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_vals("reset_async");
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      check_reset_vals("reset_hold");
    end
    Reset_n = 1'b1;
    model_reset();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vsync_pulse();
    tick_pix(0, 0, 1'b0, 1'b1, 1'b0);
    tick_pix(0, 0, 1'b0, 1'b1, 1'b0);
    tick_pix(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic hblank();
    tick_pix(0, 0, 1'b0, 1'b1, 1'b1);
    tick_pix(0, 0, 1'b0, 1'b0, 1'b1);
    tick_pix(0, 0, 1'b0, 1'b0, 1'b1);
    tick_pix(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic run_frame(input int lines, input int pix, input int chg_line, input int chg_mode);
    int y;
    vsync_pulse();
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) mode_in = 2'(chg_mode);
      y = $urandom_range(0, 599);
      for (int p = 0; p < pix; p++) tick_pix($urandom_range(0, 799), y, 1'b1, 1'b1, 1'b1);
      hblank();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    mode_in = 2'd0;
    nextX = '0; nextY = '0; mode = '0;
    blank_in_n = 1'b0; sync_in_n = 1'b1; hSync_in_n = 1'b1; vSync_in_n = 1'b1;

    // Power-on reset, then a line with an hsync pulse to expose the latency.
    do_reset(3);
    for (int i = 0; i < 6; i++) tick_pix(0, 0, 1'b0, 1'b1, 1'b1);
    hblank();

    // Colour bars across a full visible line plus the horizontal blanking.
    mode_in = 2'd1;
    vsync_pulse();
    for (int x = 0; x < 1040; x++) tick_pix(x, 10, x < 800, !(x >= 850 && x < 970), 1'b1);

    // Framebuffer reads, including the frame corners and an RGB332 red pixel.
    mode_in = 2'd0;
    vsync_pulse();
    tick_pix(799, 599, 1'b1, 1'b1, 1'b1);
    tick_pix(4, 4, 1'b1, 1'b1, 1'b1);
    tick_pix(96, 4, 1'b1, 1'b1, 1'b1);
    tick_pix(0, 0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick_pix($urandom_range(0, 799), $urandom_range(0, 599), 1'b1, 1'b1, 1'b1);
    hblank();

    // Bars with a mid-frame request for checkerboard, which waits for the next frame.
    mode_in = 2'd1;
    run_frame(6, 8, 3, 2);
    run_frame(4, 8, -1, 0);

    // Enough checkerboard frames for the counter to wrap and the phase to flip.
    mode_in = 2'd2;
    for (int f = 0; f < 260; f++) run_frame(2, 4, -1, 0);

    // Mixed random frames with random mid-frame mode requests.
    for (int f = 0; f < 20; f++) begin
      mode_in = 2'($urandom_range(0, 3));
      run_frame(3, 6, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset mid-line in framebuffer mode, then a new mode at the first boundary.
    mode_in = 2'd0;
    vsync_pulse();
    for (int x = 0; x <= 400; x++) tick_pix(x, 20, 1'b1, 1'b1, 1'b1);
    do_reset(2);
    mode_in = 2'd3;
    for (int i = 0; i < 8; i++) tick_pix($urandom_range(0, 799), 30, 1'b1, 1'b1, 1'b1);
    hblank();
    run_frame(3, 6, -1, 0);

    // Drain the pipeline so every queued prediction is compared.
    for (int i = 0; i < L + 2; i++) tick_pix(0, 0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
